shifter_sequencer: RTL and testbench
====================================

SHIFTER_SEQUENCER -- requirements
Module: shifter_sequencer

Interface
REQ-001 Parameter DELAY_WIDTH, default 30, width of delay values.
REQ-002 Parameter EVENT_WIDTH, default 4, width of event counts.
REQ-003 Parameter DEPTH, default 8, number of schedule table entries.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 cfg_wr_en  input  1  table write strobe.
REQ-007 cfg_wr_addr  input  $clog2(DEPTH)  table write index.
REQ-008 cfg_wr_delay  input  DELAY_WIDTH  entry delay.
REQ-009 cfg_wr_event  input  EVENT_WIDTH  entry event count.
REQ-010 cfg_wr_polarity  input  1  entry edge polarity (1 = falling).
REQ-011 num_entries  input  $clog2(DEPTH)+1  active entry count, sampled at start.
REQ-012 loop_en  input  1  wrap to entry 0 after last, sampled at start.
REQ-013 start  input  1  single-cycle run request.
REQ-014 abort  input  1  single-cycle stop request.
REQ-015 shf_pulse  input  1  output_signal from the controlled shifter.
REQ-016 shf_delay_value / shf_event_value  output  DELAY_WIDTH / EVENT_WIDTH  shifter config data.
REQ-017 shf_delay_set / shf_event_set  output  1  one-cycle config load strobes.
REQ-018 shf_polarity  output  1  polarity level to shifter.
REQ-019 shf_auto_start  output  1  shifter enable.
REQ-020 busy  output  1  run in progress; cur_index  output  $clog2(DEPTH)  active entry.
REQ-021 done / aborted / cfg_err  output  1  one-cycle status pulses.
REQ-022 pulse_count  output  16  shifter pulses seen since last start, saturating.

Function
REQ-023 FSM states IDLE, LOAD, ARM, WAIT; state, index, and strobe outputs registered.
REQ-024 cfg_wr_en in IDLE writes {delay, event, polarity} to table[cfg_wr_addr] next cycle; write while busy or with addr >= DEPTH is dropped and pulses cfg_err.
REQ-025 IDLE + start with 1 <= num_entries <= DEPTH: latch num_entries and loop_en, cur_index=0, pulse_count=0, go to LOAD; otherwise pulse cfg_err and stay in IDLE.
REQ-026 LOAD (1 cycle): drive table[cur_index] on shf_* data, pulse shf_delay_set and shf_event_set together, shf_auto_start=0; go to ARM.
REQ-027 ARM (1 cycle): shf_auto_start=1, data held; go to WAIT.
REQ-028 WAIT: shf_auto_start=1; on shf_pulse, increment pulse_count (saturate at 0xFFFF).
REQ-029 In WAIT, on shf_pulse with cur_index < latched count-1: increment cur_index, go to LOAD.
REQ-030 In WAIT, on shf_pulse at last entry: if loop_en, set cur_index=0 and go to LOAD; otherwise pulse done and go to IDLE.
REQ-031 Latency: start at cycle N gives set strobes at N+1 and auto_start high from N+2; shf_pulse at M gives the next set strobe or done at M+1.
REQ-032 abort in any non-IDLE state: go to IDLE next cycle with auto_start=0 and pulse aborted; abort takes priority over a same-cycle shf_pulse, which is not counted.
REQ-033 start while busy and abort in IDLE are ignored.
REQ-034 shf_pulse outside WAIT is ignored.
REQ-035 busy=1 in LOAD, ARM and WAIT.
REQ-036 shf_* data outputs hold the last loaded values in IDLE.

Reset
REQ-037 Reset clears state to IDLE, all table entries to zero, and all outputs to zero; it aborts a run without pulsing aborted.

Structure
REQ-038 Package shifter_seq_pkg holds the state enum, the entry struct {delay, event, polarity}, and default width constants.
REQ-039 Table is sub-module shifter_cfg_table: DEPTH-entry register file, one write port, one combinational read port.

Verification
REQ-040 Write entry0 {delay=5, event=2, pol=0}, num_entries=1, start -> set strobes at cycle+1, auto_start at cycle+2, pulse injected -> done next cycle, pulse_count=1.
REQ-041 Three entries, loop_en=0, three pulses -> cur_index steps 0,1,2, each entry's values appear on shf_* at its set strobe, single done, busy falls.
REQ-042 Two entries, loop_en=1, five pulses -> cur_index 0,1,0,1,0, no done, pulse_count=5.
REQ-043 abort coincident with shf_pulse in WAIT -> aborted pulse, IDLE, pulse_count unchanged, auto_start=0.
REQ-044 start with num_entries=0 or 9 -> cfg_err, busy stays 0; cfg_wr_en while busy -> cfg_err, table unchanged.
REQ-045 Reset asserted in WAIT -> all outputs 0 next cycle, table reads zero.

Source files
------------

// File: rtl/shifter_sequencer_pkg.sv
// Shared types and default widths for the shifter sequencer slice.
// The entry struct describes one schedule step as software sees it.
package shifter_seq_pkg;

  localparam int DEF_DELAY_WIDTH = 30;
  localparam int DEF_EVENT_WIDTH = 4;
  localparam int DEF_DEPTH       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_WAIT = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [DEF_DELAY_WIDTH-1:0] delay;
    logic [DEF_EVENT_WIDTH-1:0] evt;
    logic                       polarity;
  } seq_entry_t;

  // Table entries are stored as {delay, event, polarity}.
  function automatic int entry_bits(input int dw, input int ew);
    return dw + ew + 1;
  endfunction

endpackage

// File: rtl/shifter_sequencer_if.sv
// Link between the sequencer (master) and the controlled shifter (slave).
// Handshake: *_set are one-cycle load strobes qualifying the data lines; data
// is held stable until the next strobe; shf_pulse is a one-cycle event from the shifter.
interface shifter_sequencer_if import shifter_seq_pkg::*; #(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int EVENT_WIDTH = DEF_EVENT_WIDTH
);
  logic [DELAY_WIDTH-1:0] shf_delay_value;
  logic [EVENT_WIDTH-1:0] shf_event_value;
  logic                   shf_delay_set;
  logic                   shf_event_set;
  logic                   shf_polarity;
  logic                   shf_auto_start;
  logic                   shf_pulse;

  modport master (
    output shf_delay_value, shf_event_value, shf_delay_set, shf_event_set,
    output shf_polarity, shf_auto_start,
    input  shf_pulse
  );

  modport slave (
    input  shf_delay_value, shf_event_value, shf_delay_set, shf_event_set,
    input  shf_polarity, shf_auto_start,
    output shf_pulse
  );
endinterface

// File: rtl/shifter_sequencer_cfg_table.sv
// Schedule table: DEPTH-entry register file with one synchronous write port
// and one combinational read port; cleared by reset.
module shifter_cfg_table import shifter_seq_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = entry_bits(DEF_DELAY_WIDTH, DEF_EVENT_WIDTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/shifter_sequencer.sv
// Steps a controlled shifter through a programmed table of {delay, event, polarity}
// entries, advancing one entry per shifter output pulse, optionally looping.
module shifter_sequencer import shifter_seq_pkg::*; #(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int EVENT_WIDTH = DEF_EVENT_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_wr_en,
  input  logic [AW-1:0]          cfg_wr_addr,
  input  logic [DELAY_WIDTH-1:0] cfg_wr_delay,
  input  logic [EVENT_WIDTH-1:0] cfg_wr_event,
  input  logic                   cfg_wr_polarity,
  input  logic [AW:0]            num_entries,
  input  logic                   loop_en,
  input  logic                   start,
  input  logic                   abort,
  shifter_sequencer_if.master    shf,
  output logic                   busy,
  output logic [AW-1:0]          cur_index,
  output logic                   done,
  output logic                   aborted,
  output logic                   cfg_err,
  output logic [15:0]            pulse_count,
  output seq_state_e             dbg_state
);

  localparam int          EBITS   = entry_bits(DELAY_WIDTH, EVENT_WIDTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_e             state_q;
  logic [AW-1:0]          idx_q;
  logic [AW:0]            cnt_q;
  logic                   loop_q;
  logic [15:0]            pc_q;
  logic [DELAY_WIDTH-1:0] delay_q;
  logic [EVENT_WIDTH-1:0] event_q;
  logic                   pol_q;
  logic                   dset_q, eset_q, auto_q;
  logic                   done_q, aborted_q, cfg_err_q;

  logic                   addr_ok, num_ok, tbl_we, is_last;
  logic [AW-1:0]          idx_d;
  logic [EBITS-1:0]       rd_data;

  assign addr_ok = {1'b0, cfg_wr_addr} < DEPTH_L;
  assign num_ok  = (num_entries != '0) && (num_entries <= DEPTH_L);
  assign tbl_we  = cfg_wr_en && (state_q == ST_IDLE) && addr_ok;

  // The entry about to be loaded: 0 from IDLE or on wrap, else the successor.
  always_comb begin
    is_last = ({1'b0, idx_q} == (cnt_q - 1'b1));
    idx_d   = '0;
    if (state_q == ST_WAIT && !is_last) idx_d = idx_q + 1'b1;
  end

  shifter_cfg_table #(.DEPTH(DEPTH), .WIDTH(EBITS)) u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (tbl_we),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i ({cfg_wr_delay, cfg_wr_event, cfg_wr_polarity}),
    .rd_addr_i (idx_d),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      loop_q    <= 1'b0;
      pc_q      <= '0;
      delay_q   <= '0;
      event_q   <= '0;
      pol_q     <= 1'b0;
      dset_q    <= 1'b0;
      eset_q    <= 1'b0;
      auto_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      dset_q    <= 1'b0;
      eset_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= cfg_wr_en && ((state_q != ST_IDLE) || !addr_ok);
      // Abort wins over a same-cycle shifter pulse; that pulse is not counted.
      if (state_q != ST_IDLE && abort) begin
        state_q   <= ST_IDLE;
        auto_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            auto_q <= 1'b0;
            if (start) begin
              if (num_ok) begin
                cnt_q   <= num_entries;
                loop_q  <= loop_en;
                idx_q   <= '0;
                pc_q    <= '0;
                delay_q <= rd_data[EBITS-1 -: DELAY_WIDTH];
                event_q <= rd_data[EVENT_WIDTH:1];
                pol_q   <= rd_data[0];
                dset_q  <= 1'b1;
                eset_q  <= 1'b1;
                state_q <= ST_LOAD;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            auto_q  <= 1'b1;
            state_q <= ST_ARM;
          end
          ST_ARM: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (shf.shf_pulse) begin
              if (pc_q != 16'hFFFF) pc_q <= pc_q + 16'd1;
              if (!is_last || loop_q) begin
                idx_q   <= idx_d;
                delay_q <= rd_data[EBITS-1 -: DELAY_WIDTH];
                event_q <= rd_data[EVENT_WIDTH:1];
                pol_q   <= rd_data[0];
                dset_q  <= 1'b1;
                eset_q  <= 1'b1;
                auto_q  <= 1'b0;
                state_q <= ST_LOAD;
              end else begin
                done_q  <= 1'b1;
                auto_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign shf.shf_delay_value = delay_q;
  assign shf.shf_event_value = event_q;
  assign shf.shf_delay_set   = dset_q;
  assign shf.shf_event_set   = eset_q;
  assign shf.shf_polarity    = pol_q;
  assign shf.shf_auto_start  = auto_q;

  assign busy        = (state_q != ST_IDLE);
  assign cur_index   = idx_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign cfg_err     = cfg_err_q;
  assign pulse_count = pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_shifter_sequencer.sv
// Directed bench for shifter_sequencer: single step, multi-entry, looping,
// abort, configuration errors and reset in mid-run.
module tb_shifter_sequencer;
  import shifter_seq_pkg::*;

  localparam int DW    = 30;
  localparam int EW    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_wr_en;
  logic [AW-1:0]   cfg_wr_addr;
  logic [DW-1:0]   cfg_wr_delay;
  logic [EW-1:0]   cfg_wr_event;
  logic            cfg_wr_polarity;
  logic [AW:0]     num_entries;
  logic            loop_en;
  logic            start;
  logic            abort;
  logic            busy;
  logic [AW-1:0]   cur_index;
  logic            done;
  logic            aborted;
  logic            cfg_err;
  logic [15:0]     pulse_count;
  seq_state_e      dbg_state;

  shifter_sequencer_if #(.DELAY_WIDTH(DW), .EVENT_WIDTH(EW)) shf_if ();

  shifter_sequencer #(.DELAY_WIDTH(DW), .EVENT_WIDTH(EW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_delay    (cfg_wr_delay),
    .cfg_wr_event    (cfg_wr_event),
    .cfg_wr_polarity (cfg_wr_polarity),
    .num_entries     (num_entries),
    .loop_en         (loop_en),
    .start           (start),
    .abort           (abort),
    .shf             (shf_if.master),
    .busy            (busy),
    .cur_index       (cur_index),
    .done            (done),
    .aborted         (aborted),
    .cfg_err         (cfg_err),
    .pulse_count     (pulse_count),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  int tests_run    = 0;
  int tests_failed = 0;
  logic [AW-1:0] exp_q [$];
  seq_entry_t    tbl [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int a, input seq_entry_t e);
    cfg_wr_en       = 1'b1;
    cfg_wr_addr     = AW'(a);
    cfg_wr_delay    = e.delay;
    cfg_wr_event    = e.evt;
    cfg_wr_polarity = e.polarity;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic start_run(input int n, input logic lp);
    num_entries = (AW+1)'(n);
    loop_en     = lp;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse();
    shf_if.shf_pulse = 1'b1;
    tick();
    shf_if.shf_pulse = 1'b0;
  endtask

  task automatic check_load(input string tag, input int idx, input seq_entry_t e);
    check({tag, "_dset"},  32'(shf_if.shf_delay_set), 32'd1);
    check({tag, "_eset"},  32'(shf_if.shf_event_set), 32'd1);
    check({tag, "_idx"},   32'(cur_index), 32'(idx));
    check({tag, "_delay"}, 32'(shf_if.shf_delay_value), 32'(e.delay));
    check({tag, "_event"}, 32'(shf_if.shf_event_value), 32'(e.evt));
    check({tag, "_pol"},   32'(shf_if.shf_polarity), 32'(e.polarity));
    check({tag, "_auto"},  32'(shf_if.shf_auto_start), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_delay = '0;
    cfg_wr_event = '0; cfg_wr_polarity = 1'b0; num_entries = '0; loop_en = 1'b0;
    start = 1'b0; abort = 1'b0; shf_if.shf_pulse = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_auto",  32'(shf_if.shf_auto_start), 32'd0);
    check("rst_pc",    32'(pulse_count), 32'd0);
    check("rst_delay", 32'(shf_if.shf_delay_value), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single entry: strobes at N+1, auto_start at N+2, done one cycle after pulse
    wr_entry(0, '{delay: 30'd5, evt: 4'd2, polarity: 1'b0});
    start_run(1, 1'b0);
    check_load("t1_load", 0, '{delay: 30'd5, evt: 4'd2, polarity: 1'b0});
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_arm_auto", 32'(shf_if.shf_auto_start), 32'd1);
    check("t1_arm_dset", 32'(shf_if.shf_delay_set), 32'd0);
    tick();
    check("t1_wait_auto", 32'(shf_if.shf_auto_start), 32'd1);
    pulse();
    check("t1_done", 32'(done), 32'd1);
    check("t1_pc",   32'(pulse_count), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_auto_end", 32'(shf_if.shf_auto_start), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_hold_delay", 32'(shf_if.shf_delay_value), 32'd5);

    // Three entries, no loop
    tbl[0] = '{delay: 30'd10, evt: 4'd1, polarity: 1'b1};
    tbl[1] = '{delay: 30'd20, evt: 4'd3, polarity: 1'b0};
    tbl[2] = '{delay: 30'h2ABCDEF0, evt: 4'd7, polarity: 1'b1};
    for (int i = 0; i < 3; i++) wr_entry(i, tbl[i]);
    start_run(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_load($sformatf("t2_load%0d", i), i, tbl[i]);
      tick();
      tick();
      tick();
      check("t2_wait_busy", 32'(busy), 32'd1);
      pulse();
      if (i < 2) check("t2_no_done", 32'(done), 32'd0);
    end
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_pc",   32'(pulse_count), 32'd3);
    tick();
    check("t2_single_done", 32'(done), 32'd0);

    // Two entries looping, five pulses
    exp_q = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    start_run(2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      check("t3_idx", 32'(cur_index), 32'(exp_q.pop_front()));
      pulse();
      check("t3_no_done", 32'(done), 32'd0);
      check("t3_reload",  32'(shf_if.shf_delay_set), 32'd1);
    end
    check("t3_pc", 32'(pulse_count), 32'd5);
    check("t3_idx_after", 32'(cur_index), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t3_aborted", 32'(aborted), 32'd1);

    // Pulses outside WAIT ignored; abort beats a coincident pulse
    start_run(1, 1'b0);
    shf_if.shf_pulse = 1'b1;
    tick();
    tick();
    shf_if.shf_pulse = 1'b0;
    check("t4_pc_ignored", 32'(pulse_count), 32'd0);
    check("t4_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    abort = 1'b1; shf_if.shf_pulse = 1'b1;
    tick();
    abort = 1'b0; shf_if.shf_pulse = 1'b0;
    check("t4_aborted", 32'(aborted), 32'd1);
    check("t4_busy",    32'(busy), 32'd0);
    check("t4_auto",    32'(shf_if.shf_auto_start), 32'd0);
    check("t4_pc",      32'(pulse_count), 32'd0);
    check("t4_no_done", 32'(done), 32'd0);
    tick();
    check("t4_abort_pulse", 32'(aborted), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_idle_abort", 32'(aborted), 32'd0);

    // Configuration errors
    start_run(0, 1'b0);
    check("t5_err0",  32'(cfg_err), 32'd1);
    check("t5_busy0", 32'(busy), 32'd0);
    start_run(9, 1'b0);
    check("t5_err9",  32'(cfg_err), 32'd1);
    check("t5_busy9", 32'(busy), 32'd0);
    start_run(1, 1'b0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("t5_restart_ign", 32'(shf_if.shf_delay_set), 32'd0);
    check("t5_restart_st",  32'(dbg_state), 32'(ST_WAIT));
    wr_entry(0, '{delay: 30'd999, evt: 4'd15, polarity: 1'b0});
    check("t5_busy_wr_err", 32'(cfg_err), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    start_run(1, 1'b0);
    check_load("t5_tbl_kept", 0, tbl[0]);

    // Reset in WAIT clears outputs and table, no aborted pulse
    abort = 1'b1; tick(); abort = 1'b0;
    start_run(2, 1'b1);
    tick(); tick();
    pulse();
    tick(); tick();
    check("t6_pre_pc", 32'(pulse_count), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_busy",    32'(busy), 32'd0);
    check("t6_auto",    32'(shf_if.shf_auto_start), 32'd0);
    check("t6_delay",   32'(shf_if.shf_delay_value), 32'd0);
    check("t6_event",   32'(shf_if.shf_event_value), 32'd0);
    check("t6_pol",     32'(shf_if.shf_polarity), 32'd0);
    check("t6_pc",      32'(pulse_count), 32'd0);
    check("t6_idx",     32'(cur_index), 32'd0);
    check("t6_aborted", 32'(aborted), 32'd0);
    start_run(2, 1'b0);
    check_load("t6_tbl0", 0, '{delay: 30'd0, evt: 4'd0, polarity: 1'b0});
    tick(); tick();
    pulse();
    check_load("t6_tbl1", 1, '{delay: 30'd0, evt: 4'd0, polarity: 1'b0});

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
